// File: rtl/exe_divider.sv
// Multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU in EXE.
// Accepts rj/rk, iterates WIDTH steps MSB first, presents sign-fixed quotient/remainder.
module exe_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_quo,
  output logic [WIDTH-1:0] div_rem
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               signed_r;
  logic               s1_neg_r;
  logic               s2_neg_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   src1_raw_r;
  // dvd_r shifts the dividend out at the top while quotient bits enter at the bottom
  logic [WIDTH-1:0]   dvd_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   rem_r;

  logic               accept_s;
  logic               last_s;
  logic [WIDTH:0]     part_s;
  logic               ge_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign accept_s   = in_valid && (state_r == IDLE) && !cancel;
  assign last_s     = (cnt_r == CNT_LAST);
  assign part_s     = {rem_r, dvd_r[WIDTH-1]};
  assign ge_s       = (part_s >= {1'b0, dvs_r});
  assign diff_s     = part_s[WIDTH-1:0] - dvs_r;
  assign rem_step_s = ge_s ? diff_s : part_s[WIDTH-1:0];
  assign quo_step_s = {dvd_r[WIDTH-2:0], ge_s};

  // Next-state decode; cancel overrides every state
  always_comb begin
    state_s = state_r;
    if (cancel) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) state_s = CALC;
          else          state_s = IDLE;
        end
        CALC: begin
          if (last_s) state_s = DONE;
          else        state_s = CALC;
        end
        DONE: begin
          if (out_ready) state_s = IDLE;
          else           state_s = DONE;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Sign fix of the final step; divide-by-zero overrides it
  always_comb begin
    quo_fix_s = quo_step_s;
    rem_fix_s = rem_step_s;
    if (dbz_r) begin
      quo_fix_s = {WIDTH{1'b1}};
      rem_fix_s = src1_raw_r;
    end else begin
      if (signed_r && (s1_neg_r != s2_neg_r)) quo_fix_s = neg_w(quo_step_s);
      else                                     quo_fix_s = quo_step_s;
      if (signed_r && s1_neg_r) rem_fix_s = neg_w(rem_step_s);
      else                      rem_fix_s = rem_step_s;
    end
  end

  // State register and registered handshake flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r      <= CNT_ZERO;
      signed_r   <= 1'b0;
      s1_neg_r   <= 1'b0;
      s2_neg_r   <= 1'b0;
      dbz_r      <= 1'b0;
      src1_raw_r <= {WIDTH{1'b0}};
      dvd_r      <= {WIDTH{1'b0}};
      dvs_r      <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      div_quo    <= {WIDTH{1'b0}};
      div_rem    <= {WIDTH{1'b0}};
    end else if (cancel) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r      <= CNT_ZERO;
            signed_r   <= div_signed;
            s1_neg_r   <= div_signed & div_src1[WIDTH-1];
            s2_neg_r   <= div_signed & div_src2[WIDTH-1];
            dbz_r      <= (div_src2 == {WIDTH{1'b0}});
            src1_raw_r <= div_src1;
            dvd_r      <= abs_w(div_src1, div_signed);
            dvs_r      <= abs_w(div_src2, div_signed);
            rem_r      <= {WIDTH{1'b0}};
          end
        end
        CALC: begin
          rem_r <= rem_step_s;
          dvd_r <= quo_step_s;
          if (last_s) begin
            cnt_r   <= cnt_r;
            div_quo <= quo_fix_s;
            div_rem <= rem_fix_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_divider.sv
// Scoreboard bench for exe_divider: directed ops push expected results,
// a forked monitor pops and compares on every output handshake.
module tb_exe_divider;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic         div_signed;
  logic [W-1:0] div_src1;
  logic [W-1:0] div_src2;
  logic         cancel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] div_quo;
  logic [W-1:0] div_rem;

  int           cyc = 0;
  int           n_vec = 0;
  int           n_mis = 0;
  int           t_acc;
  logic [63:0]  sb_q[$];

  exe_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .cancel     (cancel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_quo    (div_quo),
    .div_rem    (div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one op; waits for in_ready, records accept cycle, scrambles operands afterwards
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input bit push,
                       output int t);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    div_signed = sgn;
    div_src1   = a;
    div_src2   = b;
    t = cyc;
    if (push) sb_q.push_back({eq, er});
    @(posedge clk); #1;
    in_valid   = 1'b0;
    div_signed = ~sgn;
    div_src1   = 32'hDEAD_BEEF;
    div_src2   = 32'h0000_0000;
  endtask

  task automatic wait_out(input int t, input bit chk_lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("out_valid_timeout", 32'd0, 32'd1);
    else if (chk_lat) chk("latency", 32'(cyc - t), 32'd33);
  endtask

  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er);
    int t;
    issue(sgn, a, b, eq, er, 1'b1, t);
    wait_out(t, 1'b1);
  endtask

  initial begin
    bit rose;
    logic [63:0] e;
    resetn     = 1'b0;
    in_valid   = 1'b0;
    cancel     = 1'b0;
    out_ready  = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;

    fork
      forever begin
        @(negedge clk);
        if (resetn && out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("quo", div_quo, e[63:32]);
            chk("rem", div_rem, e[31:0]);
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quo", div_quo, 32'd0);
    chk("rst_rem", div_rem, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Main function and overflow / divide-by-zero corners
    run(1'b0, 32'd100,        32'd7,        32'd14,        32'd2);
    run(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run(1'b1, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, 32'h1234_5678);
    run(1'b0, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, 32'h1234_5678);
    run(1'b1, 32'h8000_0001,  32'd0,        32'hFFFF_FFFF, 32'h8000_0001);

    // Back-pressure in DONE, then back-to-back op offered during the handshake cycle
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b1, t_acc);
    wait_out(t_acc, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_quo", div_quo, 32'd100);
      chk("stall_rem", div_rem, 32'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'hFFFF_FFFF;
    div_src2   = 32'd16;
    run(1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

    // Cancel in DONE drops the result
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1'b0, 32'd20, 32'd6, 32'd0, 32'd0, 1'b0, t_acc);
    wait_out(t_acc, 1'b1);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("cancel_done_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Cancel at CALC iteration 10
    issue(1'b0, 32'd12345, 32'd67, 32'd0, 32'd0, 1'b0, t_acc);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_calc_in_ready", {31'd0, in_ready}, 32'd1);
    rose = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    chk("cancel_calc_no_out", {31'd0, rose}, 32'd0);
    run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Cancel together with in_valid in IDLE: nothing accepted
    @(posedge clk); #1;
    in_valid = 1'b1;
    cancel   = 1'b1;
    div_src1 = 32'd50;
    div_src2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cancel   = 1'b0;
    @(negedge clk);
    chk("cancel_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("cancel_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset pulse mid-CALC
    issue(1'b1, 32'd55, 32'd5, 32'd0, 32'd0, 1'b0, t_acc);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_quo", div_quo, 32'd0);
    chk("midrst_rem", div_rem, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
